cs_out_buffer: RTL and testbench

Downstream stage of the CS (comparator/selector) block. It takes the 10-bit Y stream CS produces once per input sample, discards the warm-up outputs produced before the 9-sample window is full, and queues the valid results in a small FIFO. The results leave through a valid/ready handshake, so the consumer (output writer or bus bridge) may stall without losing data.

---
 rtl/cs_pkg.sv | 11 +
 rtl/cs_fifo.sv | 66 ++++++
 rtl/cs_out_buffer.sv | 96 +++++++++
 tb/tb_cs_out_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared constants and types for the CS result output buffer.
package cs_pkg;
   localparam int CS_DATA_W = 10;
   localparam int CS_WARMUP = 8;
   localparam int CS_DEPTH  = 4;

   typedef enum logic [0:0] {
      WARMUP = 1'b0,
      STREAM = 1'b1
   } cs_ob_state_t;
endpackage

// File: rtl/cs_fifo.sv
// Synchronous register-array FIFO with occupancy count and drop indication.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module cs_fifo #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;
   logic              w_push;
   logic              w_pop;

   assign full   = (r_count == CW'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_pop  = pop & ~empty & ~clr;
   assign w_push = push & ~clr & (~full | w_pop);
   assign drop   = push & ~clr & full & ~w_pop;
   assign dout   = r_mem[r_rd_ptr];
   assign count  = r_count;

   // Each entry is cleared by reset so the head word reads 0 out of reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_mem[gi] <= '0;
            end else if (w_push && (r_wr_ptr == AW'(gi))) begin
               r_mem[gi] <= din;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (clr) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end
endmodule

// File: rtl/cs_out_buffer.sv
// CS result output buffer: drops warm-up results, queues valid ones, valid/ready out.
// Define CS_OUT_BUFFER_CSUM_EN to add the running checksum of delivered words.
module cs_out_buffer #(
   parameter int DATA_W = cs_pkg::CS_DATA_W,
   parameter int DEPTH  = cs_pkg::CS_DEPTH,
   parameter int WARMUP = cs_pkg::CS_WARMUP
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     en,
   input  logic [DATA_W-1:0]        y_in,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
`ifdef CS_OUT_BUFFER_CSUM_EN
   ,
   output logic [15:0]              checksum
`endif
);
   import cs_pkg::*;

   localparam logic [7:0] LP_SKIP_LAST = 8'(WARMUP - 1);

   cs_ob_state_t r_state;
   logic [7:0]   r_skip_cnt;
   logic         r_ovf;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic         w_drop;

   assign w_push    = en & ~clr & (r_state == cs_pkg::STREAM);
   assign w_pop     = out_valid & out_ready;
   assign out_valid = ~w_empty;
   assign ovf       = r_ovf;

   cs_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .clr   (clr),
      .push  (w_push),
      .pop   (w_pop),
      .din   (y_in),
      .dout  (out_data),
      .count (count),
      .full  (w_full),
      .empty (w_empty),
      .drop  (w_drop)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= cs_pkg::WARMUP;
         r_skip_cnt <= '0;
         r_ovf      <= 1'b0;
      end else if (clr) begin
         r_state    <= cs_pkg::WARMUP;
         r_skip_cnt <= '0;
         r_ovf      <= 1'b0;
      end else begin
         if (en && (r_state == cs_pkg::WARMUP)) begin
            if (r_skip_cnt == LP_SKIP_LAST) begin
               r_state    <= cs_pkg::STREAM;
               r_skip_cnt <= '0;
            end else begin
               r_skip_cnt <= r_skip_cnt + 8'd1;
            end
         end
         // A drop can only happen against a full FIFO; ovf stays set until flushed.
         if (w_drop && w_full) r_ovf <= 1'b1;
      end
   end

`ifdef CS_OUT_BUFFER_CSUM_EN
   logic [15:0] r_checksum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_checksum <= '0;
      end else if (clr) begin
         r_checksum <= '0;
      end else if (w_pop) begin
         r_checksum <= r_checksum + 16'(out_data);
      end
   end

   assign checksum = r_checksum;
`endif
endmodule

// File: tb/tb_cs_out_buffer.sv
// Self-checking bench for cs_out_buffer: directed vector table, reset corner cases,
// and randomized traffic against a queue-based reference model.
module tb_cs_out_buffer;
   localparam int DW    = 10;
   localparam int DEPTH = 4;
   localparam int WU    = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          clr;
   logic          en;
   logic [DW-1:0] y_in;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    count;
   logic          ovf;
`ifdef CS_OUT_BUFFER_CSUM_EN
   logic [15:0]   checksum;
`endif

   always #5 clk = ~clk;

   cs_out_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .en        (en),
      .y_in      (y_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .ovf       (ovf)
`ifdef CS_OUT_BUFFER_CSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit          clr;
      bit          en;
      logic [9:0]  y;
      bit          rdy;
      bit          v;
      int          c;
      bit          o;
      logic [9:0]  d;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit c_clr, input bit c_en, input int c_y, input bit c_rdy,
                               input bit e_v, input int e_c, input bit e_o, input int e_d);
      vec_t v;
      v.clr = c_clr; v.en = c_en; v.y = 10'(c_y); v.rdy = c_rdy;
      v.v = e_v; v.c = e_c; v.o = e_o; v.d = 10'(e_d);
      vecs.push_back(v);
   endfunction

   // Reference model: words waiting, warm-up samples still to discard, sticky overflow, checksum.
   int m_q[$];
   int m_warm_left;
   bit m_ovf;
   int m_csum;

   function automatic void model_reset();
      m_q.delete();
      m_warm_left = WU;
      m_ovf       = 1'b0;
      m_csum      = 0;
   endfunction

   function automatic void model_step(input bit s_clr, input bit s_en, input int s_y, input bit s_rdy);
      if (s_clr) begin
         model_reset();
         return;
      end
      if (m_q.size() > 0 && s_rdy) m_csum = (m_csum + m_q.pop_front()) % 65536;
      if (s_en) begin
         if (m_warm_left > 0)          m_warm_left--;
         else if (m_q.size() < DEPTH)  m_q.push_back(s_y);
         else                          m_ovf = 1'b1;
      end
   endfunction

   task automatic check_model(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
      check({tag, "_count"}, 32'(count), 32'(m_q.size()));
      check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
      if (m_q.size() > 0) check({tag, "_data"}, 32'(out_data), 32'(m_q[0]));
`ifdef CS_OUT_BUFFER_CSUM_EN
      check({tag, "_csum"}, 32'(checksum), 32'(m_csum));
`endif
   endtask

   task automatic drive(input bit d_clr, input bit d_en, input int d_y, input bit d_rdy);
      clr = d_clr; en = d_en; y_in = 10'(d_y); out_ready = d_rdy;
   endtask

   task automatic step(input bit d_clr, input bit d_en, input int d_y, input bit d_rdy);
      drive(d_clr, d_en, d_y, d_rdy);
      model_step(d_clr, d_en, d_y, d_rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      drive(0, 0, 0, 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_count", 32'(count), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_data", 32'(out_data), 0);
`ifdef CS_OUT_BUFFER_CSUM_EN
      check("rst_csum", 32'(checksum), 0);
`endif
      reset = 1'b1;
      model_reset();

      // Directed vector table.
      for (int i = 0; i < WU; i++) add(0, 1, 'h3FF, 1, 0, 0, 0, 0);
      add(0, 1, 'h123, 1, 1, 1, 0, 'h123);
      add(0, 0, 0, 0, 1, 1, 0, 'h123);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 6; i++) add(0, 1, i, 0, 1, (i > 4) ? 4 : i, (i > 4), 1);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 1, (i < 3), 3 - i, 1, i + 2);
      add(1, 1, 'h3AA, 0, 0, 0, 0, 0);
      for (int i = 0; i < WU; i++) add(0, 1, 'h3FF, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 'h011 + i, 0, 1, i + 1, 0, 'h011);
      add(0, 1, 'h155, 1, 1, 4, 0, 'h012);
      add(0, 0, 0, 1, 1, 3, 0, 'h013);
      add(0, 0, 0, 1, 1, 2, 0, 'h014);
      add(0, 0, 0, 1, 1, 1, 0, 'h155);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 1, 'h021 + i, 0, 1, (i > 3) ? 4 : i + 1, (i > 3), 'h021);
      add(0, 0, 0, 1, 1, 3, 1, 'h022);
      add(1, 1, 'h3AA, 0, 0, 0, 0, 0);
      for (int i = 0; i < WU; i++) add(0, 1, 'h3FF, 0, 0, 0, 0, 0);
      add(0, 1, 'h2AB, 0, 1, 1, 0, 'h2AB);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].clr, vecs[i].en, 32'(vecs[i].y), vecs[i].rdy);
         $display("vec %0d clr=%0d en=%0d y=%03h rdy=%0d -> valid=%0d count=%0d ovf=%0d data=%03h",
                  i, vecs[i].clr, vecs[i].en, vecs[i].y, vecs[i].rdy, out_valid, count, ovf, out_data);
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].v));
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].c));
         check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].o));
         if (vecs[i].v) check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].d));
      end

      // Asynchronous reset mid-stream, checked before the next rising edge.
      for (int i = 0; i < 5; i++) step(0, 1, 'h0A0 + i, 0);
      check("pre_arst_count", 32'(count), 4);
      check("pre_arst_ovf", 32'(ovf), 1);
      #3;
      reset = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_count", 32'(count), 0);
      check("arst_ovf", 32'(ovf), 0);
      $display("async reset mid-stream -> valid=%0d count=%0d ovf=%0d", out_valid, count, ovf);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();

`ifdef CS_OUT_BUFFER_CSUM_EN
      for (int i = 0; i < WU; i++) step(0, 1, 'h3FF, 1);
      for (int i = 0; i < 70; i++) step(0, 1, 'h3FF, 1);
      step(0, 0, 0, 1);
      check("csum_70x3ff", 32'(checksum), 32'h17BA);
      check("csum_ovf", 32'(ovf), 0);
      $display("checksum after 70 x 3FF = %04h", checksum);
`endif

      // Randomized traffic with varying back-pressure.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int  rdy_pct;
         bit  r_clr;
         bit  r_en;
         bit  r_rdy;
         int  r_y;
         bit  popped;
         int  pop_word;
         rdy_pct  = ((i / 500) % 3 == 0) ? 20 : (((i / 500) % 3 == 1) ? 90 : 50);
         r_clr    = ($urandom_range(0, 199) == 0);
         r_en     = ($urandom_range(0, 99) < 65);
         r_rdy    = ($urandom_range(0, 99) < rdy_pct);
         r_y      = int'($urandom_range(0, 1023));
         popped   = (m_q.size() > 0) && r_rdy && !r_clr;
         pop_word = popped ? m_q[0] : 0;
         step(r_clr, r_en, r_y, r_rdy);
         if (popped) $display("rand %0d pop %03h count=%0d", i, pop_word, count);
         check_model($sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
